// File: rtl/dual_port_memory.sv
// Two-port word memory: a read-only instruction port and a byte-writable data port,
// sharing one array, with a 1- or 2-cycle registered read path.
module dual_port_memory #(
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    output logic                    i_valid,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_valid,
    output logic                    d_err
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    // Requests have no handshake: every cycle with req=1 (and rst=0) is an accepted
    // transfer; valid pulses once per accepted read and there is no ready/backpressure.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

    logic                  i_in_range, d_in_range;
    logic                  wr_en, wr_oor, d_rd;
    logic [IDX_W-1:0]      i_idx, d_idx;
    logic [DATA_WIDTH-1:0] d_old, merged_d, i_rdata_d, d_rdata_d;

    assign i_idx = i_addr[IDX_W-1:0];
    assign d_idx = d_addr[IDX_W-1:0];

    always_comb begin
        i_in_range = {1'b0, i_addr} < DEPTH_W;
        d_in_range = {1'b0, d_addr} < DEPTH_W;
        d_old      = mem_q[d_idx];
        merged_d   = d_old;
        for (int k = 0; k < BE_W; k++) begin
            if (d_be[k]) merged_d[8*k +: 8] = d_wdata[8*k +: 8];
        end
        wr_en  = !rst && d_req && d_we && d_in_range;
        wr_oor = !rst && d_req && d_we && !d_in_range;
        d_rd   = d_req && !d_we;
        // Write-first: an instruction read colliding with a data write sees the merged word.
        i_rdata_d = '0;
        if (i_in_range) i_rdata_d = (wr_en && (i_addr == d_addr)) ? merged_d : mem_q[i_idx];
        d_rdata_d = d_in_range ? d_old : '0;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[d_idx] <= merged_d;
    end

    logic                  s1_i_vld_q, s1_d_vld_q, s1_d_err_q, wr_err_q;
    logic [DATA_WIDTH-1:0] s1_i_data_q, s1_d_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_i_vld_q  <= 1'b0;
            s1_i_data_q <= '0;
            s1_d_vld_q  <= 1'b0;
            s1_d_data_q <= '0;
            s1_d_err_q  <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            s1_i_vld_q <= i_req;
            if (i_req) s1_i_data_q <= i_rdata_d;
            s1_d_vld_q <= d_rd;
            if (d_rd) s1_d_data_q <= d_rdata_d;
            s1_d_err_q <= d_rd && !d_in_range;
            wr_err_q   <= wr_oor;
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic                  s2_i_vld_q, s2_d_vld_q, s2_d_err_q;
        logic [DATA_WIDTH-1:0] s2_i_data_q, s2_d_data_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                s2_i_vld_q  <= 1'b0;
                s2_i_data_q <= '0;
                s2_d_vld_q  <= 1'b0;
                s2_d_data_q <= '0;
                s2_d_err_q  <= 1'b0;
            end else begin
                s2_i_vld_q <= s1_i_vld_q;
                if (s1_i_vld_q) s2_i_data_q <= s1_i_data_q;
                s2_d_vld_q <= s1_d_vld_q;
                if (s1_d_vld_q) s2_d_data_q <= s1_d_data_q;
                s2_d_err_q <= s1_d_err_q;
            end
        end

        assign i_valid = s2_i_vld_q;
        assign i_rdata = s2_i_data_q;
        assign d_valid = s2_d_vld_q;
        assign d_rdata = s2_d_data_q;
        // Write errors are not pipelined: they always report the cycle after the write.
        assign d_err   = s2_d_err_q | wr_err_q;
    end else begin : g_lat1
        assign i_valid = s1_i_vld_q;
        assign i_rdata = s1_i_data_q;
        assign d_valid = s1_d_vld_q;
        assign d_rdata = s1_d_data_q;
        assign d_err   = s1_d_err_q | wr_err_q;
    end
endmodule
